// File: rtl/ped_button_requester_if.sv
// ped_button_requester_if: pedestrian button front end <-> traffic controller signal bundle
interface ped_button_requester_if;
    logic button_raw;
    logic ack;
    logic button_pressed;
    logic wait_led;

    // Driver side: the push-button and the controller's grant, observing the request outputs
    modport master (
        output button_raw,
        output ack,
        input  button_pressed,
        input  wait_led
    );

    // Requester side
    modport slave (
        input  button_raw,
        input  ack,
        output button_pressed,
        output wait_led
    );
endinterface

// File: rtl/ped_button_requester.sv
// ped_button_requester: synchronise/debounce the pedestrian button, hold a request until ack, drive WAIT LED, enforce re-arm lockout.
// Optional build macro PED_WAIT_BLINK_EN: blink the WAIT LED while pending instead of lighting it steadily.
module ped_button_requester #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int REARM_CYCLES      = 1000,
    parameter int BLINK_HALF_CYCLES = 25000
) (
    input logic                  clk,
    input logic                  rst,
    ped_button_requester_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RA_W = $clog2(REARM_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        LOCKOUT
    } state_t;

    // Reject parameter values that would make a counter compare against a negative limit
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (REARM_CYCLES < 1) begin : g_chk_ra
        $error("REARM_CYCLES must be >= 1");
    end
    if (BLINK_HALF_CYCLES < 1) begin : g_chk_bl
        $error("BLINK_HALF_CYCLES must be >= 1");
    end

    logic            sync1_q;
    logic            sync2_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            btn_db_q;
    logic            btn_db_d;
    logic            db_prev_q;
    logic            press;
    state_t          state_q;
    state_t          state_d;
    logic [RA_W-1:0] rearm_cnt_q;
    logic [RA_W-1:0] rearm_cnt_d;
    logic            button_pressed_q;
    logic            button_pressed_d;
    logic            wait_led_q;
    logic            wait_led_d;

    // Debounce: count cycles the synchronised button disagrees with the debounced level; flip once the count fills
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) btn_db_d = ~btn_db_q;
            else db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // A press is the cycle in which the debounced level has just risen
    assign press = btn_db_q & ~db_prev_q;

    // Request FSM: IDLE waits for a press, PENDING holds the request until ack, LOCKOUT ignores the button for REARM_CYCLES
    always_comb begin
        state_d     = state_q;
        rearm_cnt_d = '0;
        case (state_q)
            IDLE:    state_d = press ? PENDING : IDLE;
            PENDING: state_d = bus.ack ? LOCKOUT : PENDING;
            LOCKOUT: begin
                if (rearm_cnt_q == RA_W'(REARM_CYCLES - 1)) state_d = IDLE;
                else rearm_cnt_d = rearm_cnt_q + RA_W'(1);
            end
            default: state_d = IDLE;
        endcase
        button_pressed_d = (state_d == PENDING);
    end

`ifdef PED_WAIT_BLINK_EN
    localparam int BL_W = $clog2(BLINK_HALF_CYCLES + 1);

    logic [BL_W-1:0] blink_cnt_q;
    logic [BL_W-1:0] blink_cnt_d;

    // WAIT LED lights on entry to PENDING, then toggles every BLINK_HALF_CYCLES; dark and counter cleared elsewhere
    always_comb begin
        blink_cnt_d = '0;
        wait_led_d  = 1'b0;
        if (state_d == PENDING) begin
            if (state_q != PENDING) wait_led_d = 1'b1;
            else if (blink_cnt_q == BL_W'(BLINK_HALF_CYCLES - 1)) wait_led_d = ~wait_led_q;
            else begin
                wait_led_d  = wait_led_q;
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

    // Blink phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blink_cnt_q <= '0;
        else blink_cnt_q <= blink_cnt_d;
    end
`else
    // WAIT LED lit steadily for as long as the request is pending
    always_comb begin
        wait_led_d = (state_d == PENDING);
    end
`endif

    // State registers; reset drops any pending request and restarts debouncing from a released button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            db_cnt_q         <= '0;
            btn_db_q         <= 1'b0;
            db_prev_q        <= 1'b0;
            state_q          <= IDLE;
            rearm_cnt_q      <= '0;
            button_pressed_q <= 1'b0;
            wait_led_q       <= 1'b0;
        end else begin
            sync1_q          <= bus.button_raw;
            sync2_q          <= sync1_q;
            db_cnt_q         <= db_cnt_d;
            btn_db_q         <= btn_db_d;
            db_prev_q        <= btn_db_q;
            state_q          <= state_d;
            rearm_cnt_q      <= rearm_cnt_d;
            button_pressed_q <= button_pressed_d;
            wait_led_q       <= wait_led_d;
        end
    end

    assign bus.button_pressed = button_pressed_q;
    assign bus.wait_led       = wait_led_q;
endmodule

// File: tb/tb_ped_button_requester.sv
// tb_ped_button_requester: directed bench with an expected-output scoreboard for ped_button_requester (DEBOUNCE=4, REARM=8, BLINK_HALF=3)
module tb_ped_button_requester;
    localparam int DB  = 4;
    localparam int RA  = 8;
    localparam int BLH = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pk       = 0;
    logic [1:0] sb[$];

    ped_button_requester_if bus_if ();

    ped_button_requester #(
        .DEBOUNCE_CYCLES  (DB),
        .REARM_CYCLES     (RA),
        .BLINK_HALF_CYCLES(BLH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Guard against a stalled simulation
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1);
    end

    // Expected WAIT LED value k cycles after entering PENDING
    function automatic logic led_at(input int k);
`ifdef PED_WAIT_BLINK_EN
        return ((k / BLH) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One clock: record what the outputs must be after the edge, then compare against the scoreboard entry
    task automatic cyc(input string tag, input logic bp);
        logic [1:0] e;
        sb.push_back({bp, bp ? led_at(pk) : 1'b0});
        pk = bp ? pk + 1 : 0;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".button_pressed"}, bus_if.button_pressed, e[1]);
        chk({tag, ".wait_led"}, bus_if.wait_led, e[0]);
    endtask

    task automatic cycles(input int n, input string tag, input logic bp);
        for (int i = 0; i < n; i++) cyc(tag, bp);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.button_raw = 1'b1;
        bus_if.ack = 1'b0;
        // Button held through reset: outputs stay 0, then a request appears 7 edges after release
        cycles(3, "in_reset", 1'b0);
        rst = 1'b0;
        cycles(6, "rst_release", 1'b0);
        cycles(1, "rst_request", 1'b1);
        bus_if.ack = 1'b1;
        cycles(1, "rst_ack", 1'b0);
        bus_if.ack = 1'b0;
        bus_if.button_raw = 1'b0;
        cycles(14, "lockout1", 1'b0);

        // Clean press: request after edge 7, ack on edge 12
        bus_if.button_raw = 1'b1;
        cycles(6, "clean_wait", 1'b0);
        cycles(5, "clean_pending", 1'b1);
        bus_if.ack = 1'b1;
        cycles(1, "clean_ack", 1'b0);
        bus_if.ack = 1'b0;
        bus_if.button_raw = 1'b0;
        cycles(14, "lockout2", 1'b0);

        // Bounce every 2 cycles for 20 cycles, then settle low: never a request
        for (int i = 0; i < 20; i++) begin
            bus_if.button_raw = ((i / 2) % 2) == 0;
            cyc("bounce", 1'b0);
        end
        bus_if.button_raw = 1'b0;
        cycles(10, "bounce_settled", 1'b0);

        // Long PENDING with a second press inside it; covers the blink pattern too
        bus_if.button_raw = 1'b1;
        cycles(6, "p4_wait", 1'b0);
        cycles(2, "p4_pending", 1'b1);
        bus_if.button_raw = 1'b0;
        cycles(8, "p4_release", 1'b1);
        bus_if.button_raw = 1'b1;
        cycles(10, "p4_press_in_pending", 1'b1);
        bus_if.ack = 1'b1;
        cycles(1, "p4_ack", 1'b0);
        bus_if.ack = 1'b0;
        // Button held through the whole lockout and beyond: no request
        cycles(20, "held_across_exit", 1'b0);
        bus_if.button_raw = 1'b0;
        cycles(10, "held_release", 1'b0);
        bus_if.button_raw = 1'b1;
        cycles(6, "repress_wait", 1'b0);
        cycles(1, "repress_request", 1'b1);

        // Press that debounces exactly in the final lockout cycle is dropped
        bus_if.button_raw = 1'b0;
        cycles(10, "t5_release", 1'b1);
        bus_if.ack = 1'b1;
        cycles(1, "t5_ack", 1'b0);
        bus_if.ack = 1'b0;
        cycles(1, "t5_lockout", 1'b0);
        bus_if.button_raw = 1'b1;
        cycles(20, "press_last_lockout", 1'b0);
        bus_if.button_raw = 1'b0;
        cycles(10, "t5_idle", 1'b0);

        // Press and ack together in IDLE enter PENDING; ack held 3 cycles gives one transition
        bus_if.button_raw = 1'b1;
        cycles(6, "t6_wait", 1'b0);
        bus_if.ack = 1'b1;
        cycles(1, "press_ack_same", 1'b1);
        cycles(2, "ack_held", 1'b0);
        bus_if.ack = 1'b0;
        cycles(12, "t6_lockout", 1'b0);
        bus_if.button_raw = 1'b0;
        cycles(10, "t6_release", 1'b0);
        // Ack held high across IDLE does not block a new request
        bus_if.ack = 1'b1;
        bus_if.button_raw = 1'b1;
        cycles(6, "held_ack_wait", 1'b0);
        cycles(1, "held_ack_request", 1'b1);
        cycles(1, "held_ack_consume", 1'b0);
        bus_if.ack = 1'b0;
        bus_if.button_raw = 1'b0;
        cycles(12, "t6b_lockout", 1'b0);

        // Reset in the middle of PENDING drops the request asynchronously
        bus_if.button_raw = 1'b1;
        cycles(6, "t7_wait", 1'b0);
        cycles(2, "t7_pending", 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst.button_pressed", bus_if.button_pressed, 1'b0);
        chk("async_rst.wait_led", bus_if.wait_led, 1'b0);
        cycles(2, "t7_in_reset", 1'b0);
        rst = 1'b0;
        cycles(6, "t7_release", 1'b0);
        cycles(1, "t7_request", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
